// File: rtl/sram_responder.sv
// Word-organised single-port SRAM slave with req/gnt/rvalid handshake,
// optional wait states before grant, byte-enabled writes and registered reads.
module sram_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    // state  | meaning
    // S_IDLE | no request pending; grants immediately when WAIT_STATES == 0
    // S_WAIT | request seen, counting r_cnt down to 0 before granting
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_gnt;
    logic [ADDR_WIDTH-3:0]   w_idx;
    logic                    w_unused;

    assign w_idx    = addr_i[ADDR_WIDTH-1:2];
    assign w_unused = ^addr_i[1:0];

    always_comb begin
        w_gnt = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE:  w_gnt = (WAIT_STATES == 0) ? req_i : 1'b0;
                S_WAIT:  w_gnt = req_i && (r_cnt == 4'd0);
                default: w_gnt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_gnt && !we_i) begin
                r_rdata <= r_mem[w_idx];
            end
            case (r_state)
                S_IDLE: begin
                    if (WAIT_STATES > 0 && req_i) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    // A withdrawn request returns to IDLE with no access.
                    if (w_gnt || !req_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; w_gnt is already low during reset.
    always_ff @(posedge clk) begin
        if (w_gnt && we_i) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: one instance with zero wait states and
// one with three; expected responses are queued at grant and checked on rvalid.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic        req0 = 1'b1, we0 = 1'b0, gnt0, rvalid0;
    logic [9:0]  addr0 = '0;
    logic [3:0]  be0 = '0;
    logic [31:0] wdata0 = '0, rdata0;

    logic        req3 = 1'b1, we3 = 1'b0, gnt3, rvalid3;
    logic [9:0]  addr3 = '0;
    logic [3:0]  be3 = '0;
    logic [31:0] wdata3 = '0, rdata3;

    typedef struct {
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        w;
        logic [9:0]  a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    exp_t q0[$];
    exp_t q3[$];
    vec_t vecs[$];

    sram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req_i(req0), .addr_i(addr0), .we_i(we0),
        .be_i(be0), .wdata_i(wdata0), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0)
    );

    sram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .req_i(req3), .addr_i(addr3), .we_i(we3),
        .be_i(be3), .wdata_i(wdata3), .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitors: rvalid/rdata only change on posedge, so negedge sampling is stable.
    always @(negedge clk) begin
        if (rvalid0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("ws0 unexpected rvalid", 32'd1, 32'd0);
            end else begin
                chk("ws0 rvalid cycle", cyc, q0[0].cyc);
                chk("ws0 rdata", rdata0, q0[0].rd);
                void'(q0.pop_front());
            end
        end else if (q0.size() != 0 && q0[0].cyc <= cyc) begin
            chk("ws0 missing rvalid", rvalid0, 32'd1);
            void'(q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rvalid3 === 1'b1) begin
            if (q3.size() == 0) begin
                chk("ws3 unexpected rvalid", 32'd1, 32'd0);
            end else begin
                chk("ws3 rvalid cycle", cyc, q3[0].cyc);
                chk("ws3 rdata", rdata3, q3[0].rd);
                void'(q3.pop_front());
            end
        end else if (q3.size() != 0 && q3[0].cyc <= cyc) begin
            chk("ws3 missing rvalid", rvalid3, 32'd1);
            void'(q3.pop_front());
        end
    end

    task automatic add(input logic w, input logic [9:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.w = w; v.a = a; v.b = b; v.d = d; v.e = e;
        vecs.push_back(v);
    endtask

    // Zero-wait access: called just after a negedge, grant expected this cycle.
    task automatic acc0(input vec_t v);
        exp_t x;
        req0 = 1'b1; we0 = v.w; addr0 = v.a; be0 = v.b; wdata0 = v.d;
        #1;
        chk("ws0 gnt same cycle", gnt0, 1'b1);
        x.rd = v.e; x.cyc = cyc + 1;
        q0.push_back(x);
    endtask

    // Three-wait access: junk on the bus until the expected grant cycle.
    task automatic acc3(input logic w, input logic [9:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] e);
        exp_t x;
        int   n;
        req3 = 1'b1;
        for (n = 0; n < 8; n++) begin
            if (n == 3) begin
                we3 = w; addr3 = a; be3 = b; wdata3 = d;
            end else begin
                we3 = ~w; addr3 = a ^ 10'h3FC; be3 = 4'hF; wdata3 = 32'hBAD0_BAD0;
            end
            #1;
            if (gnt3) break;
            @(negedge clk);
        end
        chk("ws3 grant delay", n, 32'd3);
        if (gnt3) begin
            x.rd = e; x.cyc = cyc + 1;
            q3.push_back(x);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        add(1, 10'h010, 4'hF, 32'hDEADBEEF, 32'h00000000);
        add(0, 10'h010, 4'h0, 32'h0,        32'hDEADBEEF);
        add(1, 10'h020, 4'hF, 32'hFFFFFFFF, 32'hDEADBEEF);
        add(1, 10'h020, 4'h5, 32'h12345678, 32'hDEADBEEF);
        add(0, 10'h020, 4'h0, 32'h0,        32'hFF34FF78);
        add(1, 10'h020, 4'h0, 32'h00000000, 32'hFF34FF78);
        add(0, 10'h020, 4'h0, 32'h0,        32'hFF34FF78);
        add(1, 10'h040, 4'hF, 32'h11111111, 32'hFF34FF78);
        add(0, 10'h040, 4'h0, 32'h0,        32'h11111111);
        add(1, 10'h040, 4'hF, 32'h22222222, 32'h11111111);
        add(0, 10'h040, 4'h0, 32'h0,        32'h22222222);
        add(1, 10'h040, 4'hF, 32'h33333333, 32'h22222222);
        add(0, 10'h040, 4'h0, 32'h0,        32'h33333333);
        add(1, 10'h040, 4'hF, 32'h44444444, 32'h33333333);
        add(0, 10'h040, 4'h0, 32'h0,        32'h44444444);

        // Reset held 3 cycles with requests pending on both instances.
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("reset gnt0", gnt0, 1'b0);
            chk("reset gnt3", gnt3, 1'b0);
            chk("reset rvalid0", rvalid0, 1'b0);
            chk("reset rdata0", rdata0, 32'h0);
            chk("reset rvalid3", rvalid3, 1'b0);
            chk("reset rdata3", rdata3, 32'h0);
        end

        @(negedge clk);
        reset = 1'b0;
        req3  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i != 0) @(negedge clk);
            acc0(vecs[i]);
        end
        @(negedge clk);
        req0 = 1'b0;
        #1;
        chk("ws0 idle gnt", gnt0, 1'b0);
        for (int i = 7; i < 15; i++) begin
            @(negedge clk);
            acc0(vecs[i]);
        end
        @(negedge clk);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        // Wait-state instance: writes, then back-to-back reads.
        acc3(1, 10'h000, 4'hF, 32'hA5A5A5A5, 32'h00000000);
        @(negedge clk);
        acc3(1, 10'h004, 4'hF, 32'h5A5A5A5A, 32'h00000000);
        @(negedge clk);
        acc3(0, 10'h000, 4'h0, 32'h0, 32'hA5A5A5A5);
        @(negedge clk);
        acc3(0, 10'h004, 4'h0, 32'h0, 32'h5A5A5A5A);
        @(negedge clk);
        req3 = 1'b0;
        repeat (2) @(negedge clk);

        // Withdrawal after one cycle, then a fresh request.
        req3 = 1'b1; we3 = 1'b0; addr3 = 10'h000;
        #1;
        chk("ws3 withdraw c0 gnt", gnt3, 1'b0);
        @(negedge clk);
        req3 = 1'b0;
        #1;
        chk("ws3 withdraw c1 gnt", gnt3, 1'b0);
        @(negedge clk);
        acc3(0, 10'h004, 4'h0, 32'h0, 32'h5A5A5A5A);
        @(negedge clk);
        req3 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset two cycles into a pending request.
        req3 = 1'b1; we3 = 1'b0; addr3 = 10'h000;
        #1;
        chk("ws3 pend c0 gnt", gnt3, 1'b0);
        @(negedge clk);
        #1;
        chk("ws3 pend c1 gnt", gnt3, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ws3 reset gnt", gnt3, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        req3  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("ws3 post-reset rvalid", rvalid3, 1'b0);
        end
        chk("ws3 post-reset rdata", rdata3, 32'h0);
        @(negedge clk);
        acc3(0, 10'h000, 4'h0, 32'h0, 32'hA5A5A5A5);
        @(negedge clk);
        req3 = 1'b0;
        repeat (3) @(negedge clk);

        chk("ws0 queue drained", q0.size(), 32'd0);
        chk("ws3 queue drained", q3.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
